// File: rtl/a2d_arb_pkg.sv
// Shared types and constants for the two-requester A2D arbiter.
package a2d_arb_pkg;

  localparam int CHNL_W  = 3;
  localparam int RES_W   = 12;
  localparam int NUM_REQ = 2;

  localparam logic [RES_W-1:0] RES_TIMEOUT = 12'hFFF;

  typedef enum logic {IDLE, WAIT} arb_state_t;

endpackage

// File: rtl/a2d_req_slot.sv
// One requester's private port: pending flag, channel latch, result register
// and completion pulse.
module a2d_req_slot
  import a2d_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strt,
  input  logic [CHNL_W-1:0] chnnl_in,
  input  logic              grant_done,
  input  logic [RES_W-1:0]  done_res,
  output logic              pend,
  output logic [CHNL_W-1:0] chnnl,
  output logic [RES_W-1:0]  res,
  output logic              cmplt
);

  logic              pend_q, pend_d;
  logic [CHNL_W-1:0] chnnl_q, chnnl_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              cmplt_q, cmplt_d;

  // A request arriving with this slot's own completion starts a fresh one.
  always_comb begin
    pend_d  = pend_q;
    chnnl_d = chnnl_q;
    res_d   = res_q;
    cmplt_d = grant_done;
    if (grant_done) begin
      pend_d = strt;
      res_d  = done_res;
    end else if (strt) begin
      pend_d = 1'b1;
    end
    if (strt && (!pend_q || grant_done)) chnnl_d = chnnl_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      chnnl_q <= '0;
      res_q   <= '0;
      cmplt_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      chnnl_q <= chnnl_d;
      res_q   <= res_d;
      cmplt_q <= cmplt_d;
    end
  end

  assign pend  = pend_q;
  assign chnnl = chnnl_q;
  assign res   = res_q;
  assign cmplt = cmplt_q;

endmodule

// File: rtl/a2d_arbiter.sv
// Shares one A2D interface between motion_cntrl (req0, priority) and the
// battery monitor (req1), with a starvation guard and a conversion timeout.
module a2d_arbiter
  import a2d_arb_pkg::*;
#(
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 4095,
  parameter int TO_W       = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv0,
  input  logic [2:0]  chnnl0,
  output logic        cnv_cmplt0,
  output logic [11:0] res0,
  input  logic        strt_cnv1,
  input  logic [2:0]  chnnl1,
  output logic        cnv_cmplt1,
  output logic [11:0] res1,
  output logic        a2d_strt_cnv,
  output logic [2:0]  a2d_chnnl,
  input  logic        a2d_cnv_cmplt,
  input  logic [11:0] a2d_res,
  output logic        timeout_err
);

  localparam int              CW         = $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0]   CONSEC_MAX = CW'(MAX_CONSEC);
  localparam logic [TO_W-1:0] TO_LIM     = TO_W'(TIMEOUT);

  logic [NUM_REQ-1:0]             strt_v, pend_v, done_v, cmplt_v;
  logic [NUM_REQ-1:0][CHNL_W-1:0] chin_v, ch_v;
  logic [NUM_REQ-1:0][RES_W-1:0]  res_v;
  logic [RES_W-1:0]               done_res;

  assign strt_v = {strt_cnv1, strt_cnv0};
  assign chin_v = {chnnl1, chnnl0};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    a2d_req_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .strt       (strt_v[i]),
      .chnnl_in   (chin_v[i]),
      .grant_done (done_v[i]),
      .done_res   (done_res),
      .pend       (pend_v[i]),
      .chnnl      (ch_v[i]),
      .res        (res_v[i]),
      .cmplt      (cmplt_v[i])
    );
  end

  arb_state_t      state_q, state_d;
  logic            gnt_q, gnt_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   consec_q, consec_d;
  logic            strt_q, strt_d;
  logic [2:0]      chnl_q, chnl_d;
  logic            tmo_q, tmo_d;
  logic            pick1;

  // req1 wins only when req0 is absent or has used up its consecutive quota.
  assign pick1 = pend_v[1] & (~pend_v[0] | (consec_q == CONSEC_MAX));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    strt_d   = 1'b0;
    chnl_d   = chnl_q;
    tmo_d    = 1'b0;
    done_v   = '0;
    done_res = a2d_res;
    unique case (state_q)
      IDLE: begin
        if (|pend_v) begin
          gnt_d   = pick1;
          chnl_d  = ch_v[pick1];
          strt_d  = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A completion landing on the timeout cycle still counts as a result.
        if (a2d_cnv_cmplt) begin
          done_v[gnt_q] = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q == TO_LIM) begin
          done_v[gnt_q] = 1'b1;
          done_res      = RES_TIMEOUT;
          tmo_d         = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    consec_d = consec_q;
    if (!pend_v[1]) begin
      consec_d = '0;
    end else if (state_q == IDLE && |pend_v) begin
      if (pick1)                       consec_d = '0;
      else if (consec_q != CONSEC_MAX) consec_d = consec_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      consec_q <= '0;
      strt_q   <= 1'b0;
      chnl_q   <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      consec_q <= consec_d;
      strt_q   <= strt_d;
      chnl_q   <= chnl_d;
      tmo_q    <= tmo_d;
    end
  end

  assign a2d_strt_cnv = strt_q;
  assign a2d_chnnl    = chnl_q;
  assign timeout_err  = tmo_q;
  assign cnv_cmplt0   = cmplt_v[0];
  assign cnv_cmplt1   = cmplt_v[1];
  assign res0         = res_v[0];
  assign res1         = res_v[1];

endmodule

// File: tb/tb_a2d_arbiter.sv
// Scoreboard bench for a2d_arbiter: a transaction-level model predicts every
// A2D start and every requester completion; a negedge monitor checks them.
module tb_a2d_arbiter;

  localparam int MAX_CONSEC = 4;
  localparam int TIMEOUT    = 4095;

  logic        clk, rst_n;
  logic        strt_cnv0, strt_cnv1, cnv_cmplt0, cnv_cmplt1;
  logic [2:0]  chnnl0, chnnl1, a2d_chnnl;
  logic [11:0] res0, res1, a2d_res;
  logic        a2d_strt_cnv, a2d_cnv_cmplt, timeout_err;

  a2d_arbiter #(.MAX_CONSEC(MAX_CONSEC), .TIMEOUT(TIMEOUT), .TO_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .strt_cnv0(strt_cnv0), .chnnl0(chnnl0), .cnv_cmplt0(cnv_cmplt0), .res0(res0),
    .strt_cnv1(strt_cnv1), .chnnl1(chnnl1), .cnv_cmplt1(cnv_cmplt1), .res1(res1),
    .a2d_strt_cnv(a2d_strt_cnv), .a2d_chnnl(a2d_chnnl),
    .a2d_cnv_cmplt(a2d_cnv_cmplt), .a2d_res(a2d_res), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int stamp; logic [2:0] ch; } st_t;
  typedef struct { int stamp; int who; logic [11:0] res; bit to; } cp_t;

  st_t st_q[$];
  cp_t cp_q[$];
  int  cyc = 0;
  int  n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Reference model: one conversion at a time, requests queued per requester.
  initial begin
    bit [1:0]   m_pend, pend_old, done;
    logic [2:0] m_ch[2];
    bit         m_busy;
    int         m_gnt, m_start, m_consec, g;
    m_pend = '0; m_busy = 0; m_consec = 0; m_gnt = 0; m_start = 0;
    m_ch[0] = '0; m_ch[1] = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_pend = '0; m_busy = 0; m_consec = 0;
        st_q.delete(); cp_q.delete();
      end else begin
        pend_old = m_pend;
        done = '0;
        if (m_busy) begin
          if (a2d_cnv_cmplt) begin
            cp_q.push_back('{cyc + 1, m_gnt, a2d_res, 1'b0});
            done[m_gnt] = 1'b1; m_busy = 0;
          end else if (cyc - m_start == TIMEOUT) begin
            cp_q.push_back('{cyc + 1, m_gnt, 12'hFFF, 1'b1});
            done[m_gnt] = 1'b1; m_busy = 0;
          end
        end else if (pend_old != 2'b00) begin
          g = (pend_old == 2'b10 || (pend_old == 2'b11 && m_consec == MAX_CONSEC)) ? 1 : 0;
          st_q.push_back('{cyc + 1, m_ch[g]});
          m_busy = 1; m_gnt = g; m_start = cyc + 1;
          if (g == 1) m_consec = 0;
          else if (pend_old[1] && m_consec < MAX_CONSEC) m_consec++;
        end
        if (!pend_old[1]) m_consec = 0;
        if (done[0]) m_pend[0] = 1'b0;
        if (done[1]) m_pend[1] = 1'b0;
        if (strt_cnv0 && !m_pend[0]) begin m_pend[0] = 1'b1; m_ch[0] = chnnl0; end
        if (strt_cnv1 && !m_pend[1]) begin m_pend[1] = 1'b1; m_ch[1] = chnnl1; end
      end
      cyc++;
    end
  end

  // Monitor
  initial begin
    st_t e;
    cp_t c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs",
            {cnv_cmplt0, res0, cnv_cmplt1, res1, a2d_strt_cnv, a2d_chnnl, timeout_err} == '0,
            {cnv_cmplt0, res0, cnv_cmplt1, res1, a2d_strt_cnv, a2d_chnnl, timeout_err}, 0);
      end else begin
        if (a2d_strt_cnv) begin
          if (st_q.size() == 0) chk("unexpected_a2d_strt", 1'b0, 1, 0);
          else begin
            e = st_q.pop_front();
            chk("a2d_strt_cycle", cyc == e.stamp, cyc, e.stamp);
            chk("a2d_chnnl", a2d_chnnl == e.ch, a2d_chnnl, e.ch);
          end
        end else if (st_q.size() != 0 && st_q[0].stamp <= cyc) begin
          chk("missing_a2d_strt", 1'b0, 0, st_q[0].stamp);
          st_q.delete(0);
        end
        if (cnv_cmplt0 || cnv_cmplt1) begin
          if (cp_q.size() == 0) chk("unexpected_cmplt", 1'b0, {cnv_cmplt1, cnv_cmplt0}, 0);
          else begin
            c = cp_q.pop_front();
            chk("cmplt_cycle", cyc == c.stamp, cyc, c.stamp);
            chk("cmplt_route", {cnv_cmplt1, cnv_cmplt0} == ((c.who == 1) ? 2'b10 : 2'b01),
                {cnv_cmplt1, cnv_cmplt0}, (c.who == 1) ? 2 : 1);
            if (c.who == 1) chk("res1", res1 == c.res, res1, c.res);
            else            chk("res0", res0 == c.res, res0, c.res);
            chk("timeout_err", timeout_err == c.to, timeout_err, c.to);
          end
        end else begin
          if (timeout_err) chk("stray_timeout_err", 1'b0, 1, 0);
          if (cp_q.size() != 0 && cp_q[0].stamp <= cyc) begin
            chk("missing_cmplt", 1'b0, 0, cp_q[0].stamp);
            cp_q.delete(0);
          end
        end
      end
    end
  end

  // A2D model: completes fix_dly-1 cycles after the start (random if 0).
  bit         never_cmp = 0, spur_en = 0, fix_res_en = 0;
  int         fix_dly = 0;
  logic [11:0] fix_res = '0;
  initial begin
    int cd;
    cd = 0;
    a2d_cnv_cmplt = 1'b0;
    a2d_res = '0;
    forever begin
      @(posedge clk); #1;
      a2d_cnv_cmplt = 1'b0;
      if (a2d_strt_cnv) cd = never_cmp ? 0 : ((fix_dly != 0) ? fix_dly : int'($urandom_range(1, 25)));
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          a2d_cnv_cmplt = 1'b1;
          a2d_res = fix_res_en ? fix_res : 12'($urandom);
        end
      end else if (spur_en && $urandom_range(0, 39) == 0) begin
        a2d_cnv_cmplt = 1'b1;
        a2d_res = 12'($urandom);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input bit s0, input logic [2:0] c0, input bit s1, input logic [2:0] c1);
    strt_cnv0 = s0; chnnl0 = c0; strt_cnv1 = s1; chnnl1 = c1;
    tick();
    strt_cnv0 = 1'b0; strt_cnv1 = 1'b0;
  endtask

  task automatic wait_cmplt();
    int n;
    n = 0;
    while (!a2d_cnv_cmplt && n < 2000) begin tick(); n++; end
    if (!a2d_cnv_cmplt) chk("wait_a2d_cmplt_bound", 1'b0, n, 2000);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    strt_cnv0 = 1'b0; strt_cnv1 = 1'b0; chnnl0 = '0; chnnl1 = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // single req0 conversion, fixed result
    fix_dly = 41; fix_res_en = 1'b1; fix_res = 12'h123;
    pulse(1'b1, 3'b001, 1'b0, 3'b000);
    idle(60);
    fix_res_en = 1'b0;

    // simultaneous requests
    fix_dly = 12;
    pulse(1'b1, 3'd4, 1'b1, 3'd6);
    idle(50);

    // req1 held while req0 re-requests on each completion
    fix_dly = 8;
    pulse(1'b1, 3'd2, 1'b1, 3'd5);
    repeat (6) begin
      wait_cmplt();
      pulse(1'b1, 3'($urandom), 1'b0, 3'd0);
    end
    idle(40);

    // in-flight re-request ignored; coincident one latched
    fix_dly = 20;
    pulse(1'b1, 3'd1, 1'b0, 3'd0);
    idle(4);
    pulse(1'b1, 3'd7, 1'b0, 3'd0);
    wait_cmplt();
    pulse(1'b1, 3'd5, 1'b0, 3'd0);
    idle(40);

    // conversion never completes
    never_cmp = 1'b1;
    pulse(1'b1, 3'd2, 1'b0, 3'd0);
    n = 0;
    while (!cnv_cmplt0 && n < 5000) begin tick(); n++; end
    if (!cnv_cmplt0) chk("wait_timeout_bound", 1'b0, n, 5000);
    never_cmp = 1'b0;
    fix_dly = 10;
    pulse(1'b0, 3'd0, 1'b1, 3'd3);
    idle(30);

    // reset while waiting; A2D completes after release
    fix_dly = 30;
    pulse(1'b1, 3'd3, 1'b0, 3'd0);
    idle(6);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(50);

    // random traffic with random latencies and stray A2D pulses
    fix_dly = 0; spur_en = 1'b1;
    repeat (600)
      pulse($urandom_range(0, 5) == 0, 3'($urandom), $urandom_range(0, 8) == 0, 3'($urandom));
    spur_en = 1'b0;
    idle(60);

    chk("scoreboard_drained", st_q.size() == 0 && cp_q.size() == 0, st_q.size() + cp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
